ct_merge: RTL and testbench

- N-to-1 packet merge node. The converging counterpart of the multicast split node: several flow-tagged streams join onto one output link.
- Arbitration is round-robin, and a grant holds from the first presented beat through the end-of-packet beat, so packets never interleave.
- Inputs and outputs use the same valid/ready/flow handshake as the rest of the interconnect fabric.

---
 rtl/ct_merge.sv | 93 +++++++++
 tb/tb_ct_merge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_merge.sv
// ct_merge: N-to-1 round-robin packet merge with whole-packet grant locking.
// Outputs are a zero-latency combinational mux of the granted input.
module ct_merge #(
    parameter int unsigned NI = 2,
    parameter int unsigned WO = 8,
    parameter int unsigned WF = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NI*WO-1:0] i_data,
    input  logic [NI-1:0]    i_valid,
    input  logic [NI*WF-1:0] i_flow,
    input  logic [NI-1:0]    i_eop,
    output logic [NI-1:0]    o_ready,
    output logic [WO-1:0]    o_data,
    output logic             o_valid,
    output logic [WF-1:0]    o_flow,
    output logic             o_eop,
    input  logic             i_ready
);

    localparam int unsigned WI = (NI > 1) ? $clog2(NI) : 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state;
    logic [WI-1:0] cur;
    logic [WI-1:0] rr_ptr;
    logic [WI-1:0] sel_rr;
    logic [WI-1:0] sel;
    logic [WI-1:0] sel_inc;
    logic          xfer;

    // Round-robin pick: lowest valid index >= rr_ptr, else lowest valid overall, else rr_ptr
    always_comb begin
        sel_rr = rr_ptr;
        for (int j = int'(NI) - 1; j >= 0; j--) begin
            if (i_valid[j]) begin
                sel_rr = WI'(j);
            end
        end
        for (int j = int'(NI) - 1; j >= 0; j--) begin
            if (i_valid[j] && (WI'(j) >= rr_ptr)) begin
                sel_rr = WI'(j);
            end
        end
    end

    // A locked grant ignores arbitration until its eop beat transfers
    assign sel = (state == ST_LOCKED) ? cur : sel_rr;

    // Next round-robin start, wrapping at NI-1 for any NI
    assign sel_inc = ((int'(sel) + 1) >= int'(NI)) ? '0 : WI'(int'(sel) + 1);

    // Output mux and per-input ready; everything is forced quiet during reset
    always_comb begin
        o_data  = '0;
        o_flow  = '0;
        o_eop   = 1'b0;
        o_valid = 1'b0;
        o_ready = '0;
        for (int j = 0; j < int'(NI); j++) begin
            if (WI'(j) == sel) begin
                o_data     = i_data[j*WO +: WO];
                o_flow     = i_flow[j*WF +: WF];
                o_eop      = i_eop[j];
                o_valid    = i_valid[j] & ~reset;
                o_ready[j] = i_ready & ~reset;
            end
        end
    end

    assign xfer = o_valid & i_ready;

    // Grant state: release and advance on eop transfer, lock on any other presented beat
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_OPEN;
            cur    <= '0;
            rr_ptr <= '0;
        end else if (xfer && o_eop) begin
            state  <= ST_OPEN;
            rr_ptr <= sel_inc;
        end else if (o_valid) begin
            state  <= ST_LOCKED;
            cur    <= sel;
        end
    end

endmodule

// File: tb/tb_ct_merge.sv
// tb_ct_merge: directed test of a 3-input ct_merge against a packet-level model.
module tb_ct_merge;

    localparam int NI = 3;
    localparam int WO = 8;
    localparam int WF = 2;

    logic             clk;
    logic             reset;
    logic [NI*WO-1:0] i_data;
    logic [NI-1:0]    i_valid;
    logic [NI*WF-1:0] i_flow;
    logic [NI-1:0]    i_eop;
    logic [NI-1:0]    o_ready;
    logic [WO-1:0]    o_data;
    logic             o_valid;
    logic [WF-1:0]    o_flow;
    logic             o_eop;
    logic             i_ready;

    int nvec = 0;
    int nmis = 0;

    // Model: which input owns an open packet (-1 = none) and where the next search starts
    int m_owner = -1;
    int m_ptr   = 0;

    ct_merge #(.NI(NI), .WO(WO), .WF(WF)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_flow  (i_flow),
        .i_eop   (i_eop),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_flow  (o_flow),
        .o_eop   (o_eop),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic in_valid(int j);
        return 1'((i_valid >> j) & 3'd1);
    endfunction

    function automatic logic in_eop(int j);
        return 1'((i_eop >> j) & 3'd1);
    endfunction

    function automatic logic [WO-1:0] in_data(int j);
        return WO'(i_data >> (WO * j));
    endfunction

    function automatic logic [WF-1:0] in_flow(int j);
        return WF'(i_flow >> (WF * j));
    endfunction

    // Which input the merge must be serving right now
    function automatic int model_pick();
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < NI; k++) begin
            int j;
            j = (m_ptr + k) % NI;
            if (in_valid(j)) return j;
        end
        return m_ptr;
    endfunction

    task automatic chk(string name, int got, int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    int  c_sel;
    int  c_valid;
    int  c_ready;
    always @(negedge clk) begin
        if (reset) begin
            c_valid = 0;
            c_ready = 0;
            c_sel   = 0;
        end else begin
            c_sel   = model_pick();
            c_valid = int'(in_valid(c_sel));
            c_ready = i_ready ? (1 << c_sel) : 0;
        end
        chk("model.o_valid", int'(o_valid), c_valid);
        chk("model.o_ready", int'(o_ready), c_ready);
        if (c_valid != 0) begin
            chk("model.o_data", int'(o_data), int'(in_data(c_sel)));
            chk("model.o_flow", int'(o_flow), int'(in_flow(c_sel)));
            chk("model.o_eop",  int'(o_eop),  int'(in_eop(c_sel)));
        end
    end

    // Model packet bookkeeping at each clock edge
    int u_sel;
    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
        end else begin
            u_sel = model_pick();
            if (in_valid(u_sel)) begin
                if (i_ready && in_eop(u_sel)) begin
                    m_owner = -1;
                    m_ptr   = (u_sel + 1) % NI;
                end else begin
                    m_owner = u_sel;
                end
            end
        end
    end

    task automatic drive(int j, logic v, logic [WO-1:0] d, logic [WF-1:0] f, logic e);
        i_valid = (i_valid & ~(3'b001 << j)) | (3'(v) << j);
        i_eop   = (i_eop   & ~(3'b001 << j)) | (3'(e) << j);
        i_data  = (i_data  & ~(24'hFF << (WO * j))) | (24'(d) << (WO * j));
        i_flow  = (i_flow  & ~(6'h3 << (WF * j))) | (6'(f) << (WF * j));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectation for the current cycle
    task automatic expect_out(string name, int v, int d, int f, int rdy);
        #1;
        chk({name, ".valid"}, int'(o_valid), v);
        chk({name, ".ready"}, int'(o_ready), rdy);
        if (v != 0) begin
            chk({name, ".data"}, int'(o_data), d);
            chk({name, ".flow"}, int'(o_flow), f);
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_ready = 1'b1;
        i_valid = '0;
        i_eop   = '0;
        i_data  = '0;
        i_flow  = '0;
        drive(0, 1'b1, 8'hA0, 2'd0, 1'b1);
        drive(1, 1'b1, 8'hB1, 2'd1, 1'b1);
        drive(2, 1'b1, 8'hC2, 2'd2, 1'b1);

        // Reset hold with everything valid
        step();
        step();
        expect_out("rst_hold", 0, 0, 0, 3'b000);

        // Round-robin over single-beat packets
        step(); reset = 1'b0;
        expect_out("rr0", 1, 8'hA0, 0, 3'b001);
        step(); expect_out("rr1", 1, 8'hB1, 1, 3'b010);
        step(); expect_out("rr2", 1, 8'hC2, 2, 3'b100);
        step(); expect_out("rr3", 1, 8'hA0, 0, 3'b001);

        // Idle: nothing valid, selection parks on rr_ptr=1
        step();
        drive(0, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(1, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(2, 1'b0, 8'h00, 2'd0, 1'b0);
        expect_out("idle", 0, 0, 0, 3'b010);

        // Packet lock: 4-beat packet on input 1 while input 2 waits
        step();
        drive(1, 1'b1, 8'h10, 2'd1, 1'b0);
        drive(2, 1'b1, 8'hE2, 2'd2, 1'b1);
        expect_out("lock_b1", 1, 8'h10, 1, 3'b010);
        step(); drive(1, 1'b1, 8'h11, 2'd1, 1'b0);
        expect_out("lock_b2", 1, 8'h11, 1, 3'b010);
        step(); drive(1, 1'b1, 8'h12, 2'd1, 1'b0);
        expect_out("lock_b3", 1, 8'h12, 1, 3'b010);
        step(); drive(1, 1'b1, 8'h13, 2'd1, 1'b1);
        expect_out("lock_b4", 1, 8'h13, 1, 3'b010);
        step(); drive(1, 1'b0, 8'h00, 2'd0, 1'b0);
        expect_out("lock_next", 1, 8'hE2, 2, 3'b100);

        // Single beat from input 0 moves rr_ptr to 1
        step();
        drive(2, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(0, 1'b1, 8'h5A, 2'd0, 1'b1);
        expect_out("single", 1, 8'h5A, 0, 3'b001);

        // Stall stability: input 0 held while input 2 (earlier in rotation) arrives
        step();
        drive(0, 1'b1, 8'h11, 2'd0, 1'b1);
        i_ready = 1'b0;
        expect_out("stall1", 1, 8'h11, 0, 3'b000);
        step(); drive(2, 1'b1, 8'h22, 2'd2, 1'b1);
        expect_out("stall2", 1, 8'h11, 0, 3'b000);
        step(); expect_out("stall3", 1, 8'h11, 0, 3'b000);
        step(); i_ready = 1'b1;
        expect_out("stall_xfer", 1, 8'h11, 0, 3'b001);
        step(); drive(0, 1'b0, 8'h00, 2'd0, 1'b0);
        expect_out("stall_next", 1, 8'h22, 2, 3'b100);

        // Mid-packet bubble on locked input 1 while input 0 waits
        step();
        drive(2, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(1, 1'b1, 8'h61, 2'd1, 1'b0);
        expect_out("bub_b1", 1, 8'h61, 1, 3'b010);
        step();
        drive(1, 1'b0, 8'h61, 2'd1, 1'b0);
        drive(0, 1'b1, 8'h07, 2'd0, 1'b1);
        expect_out("bub_gap1", 0, 0, 0, 3'b010);
        step(); expect_out("bub_gap2", 0, 0, 0, 3'b010);
        step(); drive(1, 1'b1, 8'h62, 2'd1, 1'b1);
        expect_out("bub_b2", 1, 8'h62, 1, 3'b010);
        step(); drive(1, 1'b0, 8'h00, 2'd0, 1'b0);
        expect_out("bub_next", 1, 8'h07, 0, 3'b001);

        // Reset during beat 2 of input 2's packet
        step();
        drive(0, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(2, 1'b1, 8'h81, 2'd2, 1'b0);
        expect_out("rmid_b1", 1, 8'h81, 2, 3'b100);
        step();
        drive(2, 1'b1, 8'h82, 2'd2, 1'b0);
        drive(0, 1'b1, 8'h09, 2'd0, 1'b1);
        reset = 1'b1;
        expect_out("rmid_rst", 0, 0, 0, 3'b000);
        step(); reset = 1'b0;
        expect_out("rmid_after", 1, 8'h09, 0, 3'b001);
        step(); drive(0, 1'b0, 8'h00, 2'd0, 1'b0);
        expect_out("rmid_resume", 1, 8'h82, 2, 3'b100);

        step();
        drive(2, 1'b0, 8'h00, 2'd0, 1'b0);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
